// File: rtl/axil_pkg.sv
// axil_pkg: shared widths, AXI response codes and master FSM states for the AXI-Lite initiator.
package axil_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int TIMEOUT_DEF = 1024;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} axil_mst_state_t;
endpackage

// File: rtl/axil_watchdog.sv
// axil_watchdog: saturating per-transaction cycle counter; expired flags the last allowed active cycle.
module axil_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [CW-1:0] r_cnt;
  // Saturating keeps expired asserted even if a handshake won on the exact expiry cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (run && r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
  assign expired = (TIMEOUT != 0) && run && (r_cnt == LAST);
endmodule

// File: rtl/axil_master.sv
// axil_master: AXI4-Lite initiator turning single emulator commands into AW/W/B or AR/R transactions,
// returning data/response, with a watchdog that aborts transactions to a dead slave.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);
  axil_mst_state_t r_state;
  logic r_cmd_ready, r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic r_aw_done, r_w_done, r_rsp_valid, r_rsp_timeout;
  logic [ADDR_W-1:0] r_awaddr, r_araddr;
  logic [DATA_W-1:0] r_wdata, r_rsp_rdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [1:0] r_rsp_resp;
  logic w_cmd_hs, w_aw_hs, w_w_hs, w_adv, w_expired, w_wd_clear, w_wd_run;

  assign w_cmd_hs = cmd_valid & r_cmd_ready;
  assign w_aw_hs = r_awvalid & AWREADY;
  assign w_w_hs = r_wvalid & WREADY;
  assign w_wd_clear = r_state == IDLE;
  assign w_wd_run = r_state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  // A state-advancing handshake on the expiry cycle beats the watchdog.
  assign w_adv = (r_state == WR_REQ) ? (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs) :
                 (r_state == WR_RESP) ? BVALID :
                 (r_state == RD_REQ) ? ARREADY :
                 (r_state == RD_RESP) ? RVALID : 1'b0;

  axil_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(ACLK), .rst(ARESET), .clear(w_wd_clear), .run(w_wd_run), .expired(w_expired)
  );

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_state <= IDLE;
      r_cmd_ready <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_bready <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_resp <= RESP_OKAY;
      r_rsp_rdata <= '0;
      r_awaddr <= '0;
      r_araddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_expired && !w_adv) begin
      // Dead slave: drop every VALID/READY mid-handshake and report SLVERR with the timeout flag.
      r_awvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_bready <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready <= 1'b0;
      r_rsp_valid <= 1'b1;
      r_rsp_timeout <= 1'b1;
      r_rsp_resp <= RESP_SLVERR;
      r_rsp_rdata <= '0;
      r_state <= RSP;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= !w_cmd_hs;
          if (w_cmd_hs && cmd_write) begin
            r_awaddr <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_wstrb <= cmd_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done <= 1'b0;
            r_state <= WR_REQ;
          end else if (w_cmd_hs) begin
            r_araddr <= cmd_addr;
            r_arvalid <= 1'b1;
            r_state <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_adv) begin
            r_bready <= 1'b1;
            r_state <= WR_RESP;
          end
        end
        WR_RESP:
          if (BVALID) begin
            r_bready <= 1'b0;
            r_rsp_resp <= BRESP;
            r_rsp_rdata <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state <= RSP;
          end
        RD_REQ:
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready <= 1'b1;
            r_state <= RD_RESP;
          end
        RD_RESP:
          if (RVALID) begin
            r_rready <= 1'b0;
            r_rsp_rdata <= RDATA;
            r_rsp_resp <= RRESP;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state <= RSP;
          end
        RSP:
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_resp = r_rsp_resp;
  assign rsp_timeout = r_rsp_timeout;
  assign AWVALID = r_awvalid;
  assign AWADDR = r_awaddr;
  assign WVALID = r_wvalid;
  assign WDATA = r_wdata;
  assign WSTRB = r_wstrb;
  assign BREADY = r_bready;
  assign ARVALID = r_arvalid;
  assign ARADDR = r_araddr;
  assign RREADY = r_rready;
endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: scoreboard bench with a configurable-latency AXI-Lite slave model.
module tb_axil_master;
  import axil_pkg::*;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0, rsp_rdata, AWADDR, WDATA, ARADDR, RDATA = '0;
  logic [3:0] cmd_wstrb = '0, WSTRB;
  logic [1:0] rsp_resp, BRESP = '0, RRESP = '0;
  logic AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;

  typedef struct packed {logic [31:0] rdata; logic [1:0] resp; logic to;} rsp_t;
  rsp_t sb[$];
  int vectors = 0, miscompares = 0;

  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  bit ar_dead = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;

  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int awv_cyc = 0, wv_cyc = 0, arv_cyc = 0, stab_err = 0, bready_early = 0;
  bit aw_got = 0, w_got = 0, r_pend = 0, prev_aw = 0, prev_ar = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0, prev_awaddr = '0, prev_araddr = '0;
  logic [3:0] last_wstrb = '0;

  axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  // Protocol monitor: handshake counters, last payloads and response-pending flags for the slave.
  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got = 0; w_got = 0; r_pend = 0; prev_aw = 0; prev_ar = 0;
    end else begin
      if (BREADY && !(aw_got && w_got)) bready_early++;
      if (prev_aw && AWVALID && AWADDR !== prev_awaddr) stab_err++;
      if (prev_ar && ARVALID && ARADDR !== prev_araddr) stab_err++;
      prev_aw = AWVALID && !AWREADY; prev_awaddr = AWADDR;
      prev_ar = ARVALID && !ARREADY; prev_araddr = ARADDR;
      if (AWVALID) awv_cyc++;
      if (WVALID) wv_cyc++;
      if (ARVALID) arv_cyc++;
      if (AWVALID && AWREADY) begin aw_hs++; aw_got = 1; last_awaddr = AWADDR; end
      if (WVALID && WREADY) begin w_hs++; w_got = 1; last_wdata = WDATA; last_wstrb = WSTRB; end
      if (BVALID && BREADY) begin b_hs++; aw_got = 0; w_got = 0; end
      if (ARVALID && ARREADY) begin ar_hs++; r_pend = 1; last_araddr = ARADDR; end
      if (RVALID && RREADY) begin r_hs++; r_pend = 0; end
    end
  end

  // Slave model: readies after N cycles of VALID, responses N cycles after the request handshakes.
  always @(negedge ACLK) begin
    AWREADY = AWVALID && aw_cnt >= aw_wait; aw_cnt = AWVALID ? aw_cnt + 1 : 0;
    WREADY = WVALID && w_cnt >= w_wait; w_cnt = WVALID ? w_cnt + 1 : 0;
    ARREADY = ARVALID && !ar_dead && ar_cnt >= ar_wait; ar_cnt = ARVALID ? ar_cnt + 1 : 0;
    BVALID = aw_got && w_got && b_cnt >= b_wait; BRESP = BVALID ? bresp_cfg : 2'b00;
    b_cnt = (aw_got && w_got) ? b_cnt + 1 : 0;
    RVALID = r_pend && r_cnt >= r_wait; RDATA = RVALID ? rdata_cfg : '0; RRESP = RVALID ? rresp_cfg : 2'b00;
    r_cnt = r_pend ? r_cnt + 1 : 0;
  end

  // lat counts cycles with the command-handshake cycle as cycle 1; it is the cycle rsp_valid is first seen.
  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] er, input logic [1:0] ep, input logic et,
                         input int hold, input bit hold_cmd, output int lat);
    rsp_t e;
    int n;
    int aw0 = aw_hs, w0 = w_hs, b0 = b_hs, ar0 = ar_hs, r0 = r_hs;
    logic [31:0] rd0;
    logic [1:0] rp0;
    e = {er, ep, et};
    sb.push_back(e);
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready); end
    @(negedge ACLK);
    cmd_valid = 0;
    lat = 2;
    while (!rsp_valid && lat < 40) begin @(negedge ACLK); lat++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rsp_arrive: rsp_valid=%b required 1", rsp_valid); end
    rd0 = rsp_rdata; rp0 = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = hold_cmd; cmd_write = 1;
      @(negedge ACLK);
      vectors++;
      if ({rsp_valid, rsp_rdata, rsp_resp, cmd_ready, AWVALID, ARVALID} !== {1'b1, rd0, rp0, 3'b000}) begin
        miscompares++;
        $display("FAIL rsp_hold[%0d]: valid=%b rdata=%h resp=%b cmd_ready=%b awv=%b arv=%b required 1 %h %b 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready, AWVALID, ARVALID, rd0, rp0);
      end
    end
    rsp_ready = 1;
    vectors++;
    if (sb.size() == 0) begin miscompares++; $display("FAIL sb_empty: response with no expectation"); end
    else begin
      e = sb.pop_front();
      vectors++;
      if (rsp_rdata !== e.rdata) begin miscompares++; $display("FAIL rsp_rdata: got %h required %h", rsp_rdata, e.rdata); end
      vectors++;
      if (rsp_resp !== e.resp) begin miscompares++; $display("FAIL rsp_resp: got %b required %b", rsp_resp, e.resp); end
      vectors++;
      if (rsp_timeout !== e.to) begin miscompares++; $display("FAIL rsp_timeout: got %b required %b", rsp_timeout, e.to); end
    end
    @(negedge ACLK);
    rsp_ready = 0; cmd_valid = 0;
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++; $display("FAIL rsp_done: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    vectors++;
    if (wr && (aw_hs - aw0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1 || last_awaddr !== a || last_wdata !== d || last_wstrb !== s)) begin
      miscompares++;
      $display("FAIL wr_channels: aw=%0d w=%0d b=%0d awaddr=%h wdata=%h wstrb=%h required 1 1 1 %h %h %h",
               aw_hs - aw0, w_hs - w0, b_hs - b0, last_awaddr, last_wdata, last_wstrb, a, d, s);
    end else if (!wr && (ar_hs - ar0 != (et ? 0 : 1) || r_hs - r0 != (et ? 0 : 1) || (!et && last_araddr !== a))) begin
      miscompares++;
      $display("FAIL rd_channels: ar=%0d r=%0d araddr=%h required %0d %0d %h",
               ar_hs - ar0, r_hs - r0, last_araddr, et ? 0 : 1, et ? 0 : 1, a);
    end
  endtask

  task automatic test_reset();
    ARESET = 1;
    @(negedge ACLK);
    vectors++;
    if ({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout} !== 8'h00) begin
      miscompares++; $display("FAIL reset_ctrl: got %b required 00000000",
                              {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout});
    end
    vectors++;
    if ({AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp} !== '0) begin
      miscompares++; $display("FAIL reset_data: awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%b required all 0",
                              AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp);
    end
    ARESET = 0;
    @(negedge ACLK);
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    int lat;
    aw_wait = 0; w_wait = 0; b_wait = 0; bresp_cfg = RESP_OKAY;
    run_cmd(1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, RESP_OKAY, 0, 0, 0, lat);
    vectors++;
    if (lat != 4) begin miscompares++; $display("FAIL wr_latency: cycle %0d required 4", lat); end
  endtask

  task automatic test_write_aw_stall();
    int lat, av0, wv0;
    av0 = awv_cyc; wv0 = wv_cyc;
    aw_wait = 3; w_wait = 0; b_wait = 0; bresp_cfg = RESP_EXOKAY;
    run_cmd(1, 32'h2000_0100, 32'h0BAD_F00D, 4'h5, 32'h0, RESP_EXOKAY, 0, 0, 0, lat);
    aw_wait = 0;
    vectors++;
    if (awv_cyc - av0 != 4 || wv_cyc - wv0 != 1) begin
      miscompares++; $display("FAIL aw_stall_valids: awvalid_cycles=%0d wvalid_cycles=%0d required 4 1", awv_cyc - av0, wv_cyc - wv0);
    end
    vectors++;
    if (lat != 7) begin miscompares++; $display("FAIL aw_stall_latency: cycle %0d required 7", lat); end
  endtask

  task automatic test_read_wait();
    int lat;
    ar_wait = 0; r_wait = 2; rdata_cfg = 32'h1234_5678; rresp_cfg = RESP_DECERR;
    run_cmd(0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678, RESP_DECERR, 0, 0, 0, lat);
    r_wait = 0;
    vectors++;
    if (lat != 6) begin miscompares++; $display("FAIL rd_latency: cycle %0d required 6", lat); end
  endtask

  task automatic test_rsp_hold();
    int lat;
    rdata_cfg = 32'hA5A5_5A5A; rresp_cfg = RESP_EXOKAY;
    run_cmd(0, 32'h0000_0050, 32'h0, 4'h0, 32'hA5A5_5A5A, RESP_EXOKAY, 0, 5, 1, lat);
  endtask

  task automatic test_timeout();
    int lat, arv0;
    arv0 = arv_cyc;
    ar_dead = 1;
    run_cmd(0, 32'h0000_0030, 32'h0, 4'h0, 32'h0, RESP_SLVERR, 1, 0, 0, lat);
    ar_dead = 0;
    vectors++;
    if (arv_cyc - arv0 != 8) begin miscompares++; $display("FAIL timeout_arvalid: cycles=%0d required 8", arv_cyc - arv0); end
    vectors++;
    if (lat != 10) begin miscompares++; $display("FAIL timeout_latency: cycle %0d required 10", lat); end
    rdata_cfg = 32'hCAFE_F00D; rresp_cfg = RESP_OKAY;
    run_cmd(0, 32'h0000_0040, 32'h0, 4'h0, 32'hCAFE_F00D, RESP_OKAY, 0, 0, 0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic wr;
    logic [31:0] a, d;
    logic [3:0] s;
    for (int k = 0; k < 8; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = $urandom & 32'hFFFF_FFFC; d = $urandom; s = 4'($urandom);
      aw_wait = $urandom_range(0, 2); w_wait = $urandom_range(0, 2); b_wait = $urandom_range(0, 2);
      ar_wait = $urandom_range(0, 2); r_wait = $urandom_range(0, 2);
      bresp_cfg = 2'($urandom); rresp_cfg = 2'($urandom); rdata_cfg = $urandom;
      run_cmd(wr, a, d, s, wr ? 32'h0 : rdata_cfg, wr ? bresp_cfg : rresp_cfg, 0, $urandom_range(0, 2), 0, lat);
    end
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit saw;
    b_wait = 20;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h3000_0000; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'h3;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    cmd_valid = 0;
    n = 0;
    while (!BREADY && n < 6) begin @(negedge ACLK); n++; end
    vectors++;
    if (BREADY !== 1'b1) begin miscompares++; $display("FAIL mid_reach_wr_resp: BREADY=%b required 1", BREADY); end
    ARESET = 1;
    #1;
    vectors++;
    if ({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, AWADDR, WDATA, WSTRB} !== '0) begin
      miscompares++; $display("FAIL mid_reset_outputs: ctrl=%b awaddr=%h wdata=%h wstrb=%h required all 0",
                              {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout}, AWADDR, WDATA, WSTRB);
    end
    @(negedge ACLK);
    ARESET = 0; b_wait = 0;
    saw = 0;
    repeat (6) begin @(negedge ACLK); if (rsp_valid) saw = 1; end
    vectors++;
    if ({saw, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL mid_reset_after: rsp_seen=%b cmd_ready=%b required 0 1", saw, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_aw_stall();
    test_read_wait();
    test_rsp_hold();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL sb_leftover: %0d entries required 0", sb.size()); end
    vectors++;
    if (stab_err != 0) begin miscompares++; $display("FAIL payload_stable: %0d changes required 0", stab_err); end
    vectors++;
    if (bready_early != 0) begin miscompares++; $display("FAIL bready_early: %0d cycles required 0", bready_early); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
